// File: rtl/dct_transpose_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : dct_transpose_pingpong
// Purpose  : N x N double-buffered transpose buffer between the row-pass and
//            column-pass 1-D DCT stages. Rows are written into one bank while
//            columns of the previous block are read from the other bank.
// Revision : 1.0 - initial release
// ============================================================================
module dct_transpose_pingpong #(
  parameter int DATA_W = 12,
  parameter int N      = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [N*DATA_W-1:0]   i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [N*DATA_W-1:0]   o_data,
  output logic                  o_last
);

  localparam int              C_AW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [C_AW-1:0] C_LAST = C_AW'(N - 1);

  // Two banks of N x N samples; contents are only meaningful once a bank is full.
  logic [DATA_W-1:0] r_mem_q [2][N][N];

  logic            r_wr_bank_q, w_wr_bank_d;
  logic [C_AW-1:0] r_wr_row_q,  w_wr_row_d;
  logic            r_rd_bank_q, w_rd_bank_d;
  logic [C_AW-1:0] r_rd_col_q,  w_rd_col_d;
  logic [1:0]      r_full_q,    w_full_d;

  logic w_wr_acc;
  logic w_rd_acc;

  // Handshake flags come straight from registers, so there is no path from
  // i_valid to o_ready or from i_ready to o_valid.
  assign o_ready  = !r_full_q[r_wr_bank_q];
  assign o_valid  = r_full_q[r_rd_bank_q];
  assign o_last   = o_valid && (r_rd_col_q == C_LAST);
  assign w_wr_acc = i_valid && o_ready;
  assign w_rd_acc = o_valid && i_ready;

  // Next-state for the write/read pointers and per-bank full flags.
  always_comb begin
    w_wr_bank_d = r_wr_bank_q;
    w_wr_row_d  = r_wr_row_q;
    w_rd_bank_d = r_rd_bank_q;
    w_rd_col_d  = r_rd_col_q;
    w_full_d    = r_full_q;

    if (w_wr_acc) begin
      w_wr_row_d = r_wr_row_q + 1'b1;
      if (r_wr_row_q == C_LAST) begin
        w_wr_row_d            = '0;
        w_full_d[r_wr_bank_q] = 1'b1;
        w_wr_bank_d           = !r_wr_bank_q;
      end
    end

    // Set and clear never hit the same bank: a full bank cannot be written.
    if (w_rd_acc) begin
      w_rd_col_d = r_rd_col_q + 1'b1;
      if (r_rd_col_q == C_LAST) begin
        w_rd_col_d            = '0;
        w_full_d[r_rd_bank_q] = 1'b0;
        w_rd_bank_d           = !r_rd_bank_q;
      end
    end
  end

  // Pointer and flag registers; reset discards any partial or full blocks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_bank_q <= 1'b0;
      r_wr_row_q  <= '0;
      r_rd_bank_q <= 1'b0;
      r_rd_col_q  <= '0;
      r_full_q    <= 2'b00;
    end else begin
      r_wr_bank_q <= w_wr_bank_d;
      r_wr_row_q  <= w_wr_row_d;
      r_rd_bank_q <= w_rd_bank_d;
      r_rd_col_q  <= w_rd_col_d;
      r_full_q    <= w_full_d;
    end
  end

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_col
      // Store sample k of an accepted row into column k of the write bank.
      always_ff @(posedge i_clk) begin
        if (w_wr_acc && !i_rst) begin
          r_mem_q[r_wr_bank_q][r_wr_row_q][k] <= i_data[k*DATA_W +: DATA_W];
        end
      end

      // Output sample k is row k of the current read column.
      assign o_data[k*DATA_W +: DATA_W] = r_mem_q[r_rd_bank_q][k][r_rd_col_q];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_dct_transpose_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : tb_dct_transpose_pingpong
// Purpose  : Self-checking bench for dct_transpose_pingpong with a block-level
//            reference model (queue of completed blocks) and directed tests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dct_transpose_pingpong;

  localparam int N      = 8;
  localparam int DATA_W = 12;
  localparam int W      = N * DATA_W;

  logic         clk = 1'b0;
  logic         i_rst = 1'b0;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [W-1:0] i_data = '0;
  logic         o_valid;
  logic         i_ready = 1'b0;
  logic [W-1:0] o_data;
  logic         o_last;

  int n_tests = 0;
  int n_fail  = 0;

  dct_transpose_pingpong #(.DATA_W(DATA_W), .N(N)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_last  (o_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Row with sample c = base + c.
  function automatic logic [W-1:0] mkrow(input int base);
    logic [W-1:0] v;
    for (int c = 0; c < N; c++) v[c*DATA_W +: DATA_W] = DATA_W'(base + c);
    return v;
  endfunction

  // Column with sample k = base + 16*k.
  function automatic logic [W-1:0] mkcol(input int base);
    logic [W-1:0] v;
    for (int k = 0; k < N; k++) v[k*DATA_W +: DATA_W] = DATA_W'(base + 16 * k);
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] smp(input int k);
    return o_data[k*DATA_W +: DATA_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Completed blocks awaiting read (row-major, N*N samples each), the partial
  // block being written, and the column index within the front block.
  logic [DATA_W-1:0] m_blocks[$];
  logic [DATA_W-1:0] m_part[N*N];
  int                m_rows  = 0;
  int                m_col   = 0;
  bit                m_armed = 1'b0;
  bit                p_hold  = 1'b0;
  logic [W-1:0]      p_data;
  logic              p_last;

  always @(negedge clk) begin : model_cmp
    int           nblk;
    bit           wr, rd;
    logic [W-1:0] ev;
    if (i_rst) begin
      m_blocks.delete();
      m_rows  = 0;
      m_col   = 0;
      m_armed = 1'b1;
      p_hold  = 1'b0;
    end else if (m_armed) begin
      nblk = m_blocks.size() / (N * N);
      chk("m_ready", o_ready, nblk < 2);
      chk("m_valid", o_valid, nblk > 0);
      if (nblk > 0) begin
        for (int k = 0; k < N; k++) ev[k*DATA_W +: DATA_W] = m_blocks[k*N + m_col];
        chk("m_data", o_data, ev);
        chk("m_last", o_last, m_col == N - 1);
      end
      if (p_hold) begin
        chk("stall_valid", o_valid, 1'b1);
        chk("stall_data", o_data, p_data);
        chk("stall_last", o_last, p_last);
      end
      p_hold = o_valid && !i_ready;
      p_data = o_data;
      p_last = o_last;

      wr = i_valid && (nblk < 2);
      rd = i_ready && (nblk > 0);
      if (rd) begin
        m_col++;
        if (m_col == N) begin
          m_col = 0;
          repeat (N * N) void'(m_blocks.pop_front());
        end
      end
      if (wr) begin
        for (int c = 0; c < N; c++) m_part[m_rows*N + c] = i_data[c*DATA_W +: DATA_W];
        m_rows++;
        if (m_rows == N) begin
          m_rows = 0;
          for (int i = 0; i < N * N; i++) m_blocks.push_back(m_part[i]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int wrows, rcols, guard;

    // Reset
    i_rst = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_last", o_last, 1'b0);

    // Single block, consumer stalled
    for (int r = 0; r < N; r++) begin
      i_valid = 1'b1;
      i_data  = mkrow(16 * r);
      chk("blk_ready", o_ready, 1'b1);
      if (r == N - 1) chk("blk_valid_early", o_valid, 1'b0);
      tick();
    end
    i_valid = 1'b0;
    chk("blk_valid_rise", o_valid, 1'b1);
    chk("blk_col0", o_data, mkcol(0));
    chk("blk_ready_after", o_ready, 1'b1);

    // Drain
    i_ready = 1'b1;
    for (int c = 0; c < N; c++) begin
      chk("drain_col", o_data, mkcol(c));
      chk("drain_last", o_last, c == N - 1);
      tick();
    end
    i_ready = 1'b0;
    chk("drain_empty", o_valid, 1'b0);

    // Streaming 4 blocks
    for (int i = 0; i < 5 * N; i++) begin
      i_valid = (i < 4 * N);
      i_data  = mkrow(32'h100 * (i / N) + 16 * (i % N));
      i_ready = 1'b1;
      if (i < 4 * N) chk("stream_ready", o_ready, 1'b1);
      if (i >= N)    chk("stream_valid", o_valid, 1'b1);
      if (i == 2 * N) chk("stream_b1c0", smp(1), 12'h110);
      if (i == 2 * N - 1 || i == 5 * N - 1) chk("stream_last", o_last, 1'b1);
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    chk("stream_empty", o_valid, 1'b0);

    // Backpressure: 17 row attempts with consumer stalled
    for (int a = 0; a <= 2 * N; a++) begin
      i_valid = 1'b1;
      i_data  = mkrow(16 * a);
      chk("bp_ready", o_ready, a < 2 * N);
      tick();
    end
    tick();
    chk("bp_ready_hold", o_ready, 1'b0);
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int c = 0; c < N; c++) begin
      if (c == 0) begin
        chk("bp_b0_s0", smp(0), 12'h000);
        chk("bp_b0_s7", smp(7), 12'h070);
      end
      chk("bp_ready_drain", o_ready, 1'b0);
      tick();
    end
    chk("bp_ready_back", o_ready, 1'b1);
    for (int c = 0; c < N; c++) begin
      if (c == 0) chk("bp_b1_s0", smp(0), 12'h080);
      tick();
    end
    i_ready = 1'b0;
    chk("bp_empty", o_valid, 1'b0);

    // Random stalls, 10 blocks
    wrows = 0;
    rcols = 0;
    guard = 0;
    while (rcols < 10 * N && guard < 20000) begin
      i_valid = (wrows < 10 * N) && ($urandom_range(1, 0) == 1);
      i_data  = mkrow(((wrows / N) * 37 + 16 * (wrows % N)) & 12'hFF0);
      i_ready = ($urandom_range(1, 0) == 1);
      if (i_valid && o_ready) wrows++;
      if (o_valid && i_ready) rcols++;
      tick();
      guard++;
    end
    chk("rand_done", rcols, 10 * N);
    i_valid = 1'b0;
    i_ready = 1'b0;
    tick();
    chk("rand_empty", o_valid, 1'b0);

    // Reset mid-block
    for (int r = 0; r < 5; r++) begin
      i_valid = 1'b1;
      i_data  = mkrow(32'h400 + 16 * r);
      tick();
    end
    i_valid = 1'b0;
    i_rst   = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("mrst_valid", o_valid, 1'b0);
    chk("mrst_ready", o_ready, 1'b1);
    for (int r = 0; r < N; r++) begin
      i_valid = 1'b1;
      i_data  = mkrow(32'h800 + 16 * r);
      chk("mrst_valid_early", o_valid, 1'b0);
      tick();
    end
    i_valid = 1'b0;
    chk("mrst_valid_rise", o_valid, 1'b1);
    chk("mrst_col0", o_data, mkcol(32'h800));
    i_ready = 1'b1;
    for (int c = 0; c < N; c++) tick();
    i_ready = 1'b0;
    chk("mrst_empty", o_valid, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
